judge_arbiter: RTL and testbench
================================

JUDGE_ARBITER -- requirements
Module: judge_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max WAIT cycles before a forced timeout result; legal range 1..255.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port req  input  4  per-requester service request, level-sensitive.
REQ-005 Port gnt  output  4  one-hot grant, held for the whole service.
REQ-006 Port res_start  output  1  one-cycle start pulse to the shared judge unit.
REQ-007 Port res_sel  output  2  index of the granted requester, driven to the judge unit.
REQ-008 Port res_done  input  1  judge unit completion strobe.
REQ-009 Port res_judge  input  3  judge unit result, valid when res_done=1.
REQ-010 Port out_valid  output  1  one-cycle result-valid pulse.
REQ-011 Port out_id  output  2  requester index of the reported result.
REQ-012 Port out_judge  output  3  reported judge value.
REQ-013 Port timeout  output  1  high with out_valid when the result was forced by timeout.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, START, WAIT, REPORT.
REQ-016 In IDLE with req!=0, it SHALL select the first set req bit searching upward from rr_ptr, wrapping 3->0, register gnt/res_sel, and enter START next cycle.
REQ-017 In IDLE with req==0, it SHALL stay in IDLE with gnt=0.
REQ-018 START SHALL last exactly one cycle with res_start=1, clear wait_cnt to 0, then enter WAIT.
REQ-019 res_done SHALL be sampled only in WAIT; res_done in IDLE, START or REPORT is ignored.
REQ-020 In WAIT with res_done=1, the block SHALL latch res_judge into out_judge, clear the timeout flag, and enter REPORT.
REQ-021 In WAIT with res_done=0, wait_cnt (8 bits) SHALL increment; when wait_cnt==TIMEOUT-1 it SHALL enter REPORT with out_judge=3'b111 and the timeout flag set.
REQ-022 If res_done=1 in the same cycle as the timeout condition, res_done SHALL win (normal result, timeout=0).
REQ-023 REPORT SHALL last one cycle with out_valid=1, out_id=res_sel; timeout=1 only for a forced result.
REQ-024 In REPORT, rr_ptr SHALL become (granted index + 1) mod 4, gnt SHALL clear at exit, and the FSM SHALL return to IDLE.
REQ-025 Deasserting the granted req bit mid-service SHALL NOT abort the service; it completes and reports normally.
REQ-026 New or changed req bits during START/WAIT/REPORT SHALL NOT affect the current grant; they are arbitrated on the next IDLE cycle.
REQ-027 Latency from IDLE arbitration to out_valid SHALL be 3 + N cycles, where N is the number of WAIT cycles (N>=1).
REQ-028 gnt SHALL be one-hot or zero at all times; res_sel, out_id and out_judge SHALL hold their value between services.

Reset
REQ-029 On reset=1 at a clock edge, state=IDLE, rr_ptr=0, wait_cnt=0, and gnt, res_start, res_sel, out_valid, out_id, out_judge, timeout and busy SHALL all be 0.
REQ-030 Reset asserted mid-service SHALL abort it with no out_valid pulse; a later res_done SHALL be ignored.
REQ-031 The first grant after reset SHALL give requester 0 highest priority.

Verification
REQ-032 Single request: reset, req=4'b0100, res_done with res_judge=3'b101 on the 2nd WAIT cycle -> gnt=4'b0100, res_sel=2, one res_start pulse, out_valid with out_id=2, out_judge=5, timeout=0, 5 cycles after arbitration.
REQ-033 Round-robin fairness: req=4'b1111 held, judge unit answers in 1 cycle -> grants in order 0,1,2,3,0, with gnt never multi-hot.
REQ-034 Timeout: TIMEOUT=15, req=4'b0001, res_done never asserted -> out_valid after 15 WAIT cycles with out_judge=3'b111 and timeout=1, then rr_ptr=1.
REQ-035 Done/timeout collision: res_done=1 with res_judge=3'b010 exactly on the timeout cycle -> out_judge=2 and timeout=0.
REQ-036 Reset mid-WAIT: reset during WAIT, then res_done=1 -> no out_valid, all outputs 0, and the next req=4'b1000 is granted from rr_ptr=0.
REQ-037 Request drop: req bit 1 granted, then deasserted in WAIT, then res_done -> result reported with out_id=1.

Source files
------------

// File: rtl/judge_arbiter.sv
// Round-robin arbiter that hands one of four requesters to a shared judge
// unit, waits for its result (or a timeout) and reports it as a one-cycle pulse.
module judge_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       res_start,
  output logic [1:0] res_sel,
  input  logic       res_done,
  input  logic [2:0] res_judge,
  output logic       out_valid,
  output logic [1:0] out_id,
  output logic [2:0] out_judge,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, REPORT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] rr_ptr;
  logic [7:0] wait_cnt;
  logic [1:0] pick;

  // First set request at or above ptr, wrapping 3->0; the loop runs from the
  // farthest offset down so the nearest one is assigned last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) sel = idx;
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, rr_ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      wait_cnt  <= 8'd0;
      gnt       <= 4'd0;
      res_start <= 1'b0;
      res_sel   <= 2'd0;
      out_valid <= 1'b0;
      out_id    <= 2'd0;
      out_judge <= 3'd0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_start <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 4'd0) begin
            gnt       <= 4'd1 << pick;
            res_sel   <= pick;
            res_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the timeout cycle still counts as a real result.
          if (res_done) begin
            out_judge <= res_judge;
            timeout   <= 1'b0;
            out_id    <= res_sel;
            out_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TO_LAST) begin
              out_judge <= 3'b111;
              timeout   <= 1'b1;
              out_id    <= res_sel;
              out_valid <= 1'b1;
              state     <= REPORT;
            end
          end
        end
        REPORT: begin
          rr_ptr  <= res_sel + 2'd1;
          gnt     <= 4'd0;
          timeout <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_judge_arbiter.sv
// Self-checking bench for judge_arbiter: table of services with a result
// scoreboard, plus hand-written reset and idle-strobe sequences.
module tb_judge_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       res_start;
  logic [1:0] res_sel;
  logic       res_done;
  logic [2:0] res_judge;
  logic       out_valid;
  logic [1:0] out_id;
  logic [2:0] out_judge;
  logic       timeout;
  logic       busy;

  judge_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .res_start(res_start),
    .res_sel(res_sel), .res_done(res_done), .res_judge(res_judge),
    .out_valid(out_valid), .out_id(out_id), .out_judge(out_judge),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mid;
    int         nd;
    logic [2:0] j;
    logic [1:0] id;
    logic [2:0] ej;
    logic       eto;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [2:0] j;
    logic       to;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every result pulse.
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt_onehot", ($countones(gnt) <= 1), 1);
      if (res_start) starts++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_id", out_id, e.id);
          chk("out_judge", out_judge, e.j);
          chk("timeout", timeout, e.to);
        end
      end
    end
  end

  task automatic service(input vec_t v);
    int k;
    int s0;
    int expn;
    exp_t e;
    expn = (v.nd >= 1 && v.nd <= TIMEOUT) ? v.nd : TIMEOUT;
    e.id = v.id; e.j = v.ej; e.to = v.eto;
    sb.push_back(e);
    s0 = starts;
    req = v.req;
    tick();
    chk("gnt_at_start", gnt, 4'd1 << v.id);
    chk("res_sel", res_sel, v.id);
    chk("res_start", res_start, 1);
    chk("busy_start", busy, 1);
    req = v.mid;
    tick();
    k = 1;
    while (!out_valid && k <= 300) begin
      res_done = (k == v.nd);
      res_judge = v.j;
      tick();
      k++;
    end
    res_done = 1'b0;
    chk("wait_cycles", k - 1, expn);
    chk("gnt_held", gnt, 4'd1 << v.id);
    req = 4'd0;
    tick();
    chk("gnt_clear", gnt, 0);
    chk("busy_idle", busy, 0);
    chk("out_judge_hold", out_judge, v.ej);
    chk("out_id_hold", out_id, v.id);
    chk("start_pulses", starts - s0, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //         req      mid      nd  j     id  ej    eto
    tbl[0]  = '{4'b1111, 4'b1111, 1,  3'd3, 2'd0, 3'd3, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 1,  3'd4, 2'd1, 3'd4, 1'b0};
    tbl[2]  = '{4'b1111, 4'b1111, 1,  3'd5, 2'd2, 3'd5, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, 1,  3'd6, 2'd3, 3'd6, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1111, 1,  3'd1, 2'd0, 3'd1, 1'b0};
    tbl[5]  = '{4'b0100, 4'b0000, 2,  3'd5, 2'd2, 3'd5, 1'b0};
    tbl[6]  = '{4'b0001, 4'b0001, 0,  3'd0, 2'd0, 3'd7, 1'b1};
    tbl[7]  = '{4'b0011, 4'b0000, 3,  3'd1, 2'd1, 3'd1, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0000, 15, 3'd2, 2'd0, 3'd2, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0000, 2,  3'd4, 2'd1, 3'd4, 1'b0};
    tbl[10] = '{4'b0101, 4'b1010, 1,  3'd1, 2'd2, 3'd1, 1'b0};
    tbl[11] = '{4'b1001, 4'b0000, 16, 3'd0, 2'd3, 3'd7, 1'b1};
    tbl[12] = '{4'b0110, 4'b0000, 1,  3'd0, 2'd1, 3'd0, 1'b0};

    reset = 1'b1; req = 4'd0; res_done = 1'b0; res_judge = 3'd0;
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_res_start", res_start, 0);
    chk("rst_res_sel", res_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_judge", out_judge, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // A completion strobe while idle must not produce a result.
    res_done = 1'b1; res_judge = 3'd6;
    tick();
    tick();
    res_done = 1'b0;
    chk("idle_done_valid", out_valid, 0);
    chk("idle_done_busy", busy, 0);

    for (int i = 0; i < 13; i++) service(tbl[i]);

    // Abort a service in WAIT, then prove the pointer went back to 0.
    req = 4'b0100;
    tick();
    chk("abort_gnt", gnt, 4'b0100);
    req = 4'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_gnt_zero", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_judge", out_judge, 0);
    chk("abort_out_id", out_id, 0);
    chk("abort_res_sel", res_sel, 0);
    res_done = 1'b1; res_judge = 3'd5;
    tick();
    tick();
    res_done = 1'b0;
    chk("abort_no_valid", out_valid, 0);
    chk("abort_idle", busy, 0);
    service('{4'b1010, 4'b0000, 1, 3'd3, 2'd1, 3'd3, 1'b0});
    service('{4'b1000, 4'b0000, 2, 3'd6, 2'd3, 3'd6, 1'b0});

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
